// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and constants for the clock-switch sequencer.
//   state_t   : sequencer states
//   SEL_CLK1  : select value that routes clk1 to the mux output
//   SEL_CLK2  : select value that routes clk2 to the mux output
package clk_switch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

endpackage

// File: rtl/clk_alive_mon.sv
// clk2 liveness monitor: synchronizes clk2 (sampled as data) into the clk1
// domain and counts its transitions while enabled.
//   clk1      in   sampling clock
//   rstn      in   asynchronous active-low reset
//   clk2_mon  in   clk2 routed as data
//   clear     in   holds the edge counter at zero
//   edge_cnt  out  saturating count of synchronized clk2 transitions
//   pass      out  edge_cnt has reached MIN_EDGES
module clk_alive_mon #(
  parameter int CNT_W     = 8,
  parameter int MIN_EDGES = 4
) (
  input  logic             clk1,
  input  logic             rstn,
  input  logic             clk2_mon,
  input  logic             clear,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             pass
);

  localparam logic [CNT_W-1:0] MIN_EDGES_W = CNT_W'(MIN_EDGES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             hist_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic             toggle;

  // The synchronizer and history flop run continuously so that entering the
  // check window never produces a false transition from stale history.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
    end else begin
      sync1_reg <= clk2_mon;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign toggle = sync2_reg ^ hist_reg;

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      edge_cnt_reg <= '0;
    end else if (clear) begin
      edge_cnt_reg <= '0;
    end else if (toggle && (edge_cnt_reg != '1)) begin
      edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
    end
  end

  assign edge_cnt = edge_cnt_reg;
  assign pass     = (edge_cnt_reg >= MIN_EDGES_W);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitch-free two-clock switch. Accepts a one-cycle request
// from the host, verifies clk2 is toggling before selecting it, drives the
// switch select, waits a settle window and reports with a one-cycle ack.
//   clk1      in   system clock (always running)
//   rstn      in   asynchronous active-low reset
//   clk2_mon  in   clk2 routed as data for the liveness check
//   req       in   one-cycle switch request
//   req_sel   in   requested clock, valid with req (1 = clk1, 0 = clk2)
//   busy      out  sequencer not idle
//   ack       out  one-cycle completion pulse
//   err       out  valid with ack: clk2 liveness check failed
//   sel_clk1  out  select to the clock switch
//   cur_sel   out  committed selection, updated with ack
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 32,
  parameter int CHK_WINDOW    = 64,
  parameter int CHK_MIN_EDGES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk1,
  input  logic rstn,
  input  logic clk2_mon,
  input  logic req,
  input  logic req_sel,
  output logic busy,
  output logic ack,
  output logic err,
  output logic sel_clk1,
  output logic cur_sel
);

  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(CHK_WINDOW - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             target_reg, target_next;
  logic             sel_reg, sel_next;
  logic             err_next;
  logic             cur_sel_reg;
  logic             ack_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             alive_pass;
  logic [CNT_W-1:0] alive_edges;

  // Edge counter only runs while in CHECK, so it is zero on every entry.
  clk_alive_mon #(
    .CNT_W     (CNT_W),
    .MIN_EDGES (CHK_MIN_EDGES)
  ) u_alive_mon (
    .clk1     (clk1),
    .rstn     (rstn),
    .clk2_mon (clk2_mon),
    .clear    (state_reg != CHECK),
    .edge_cnt (alive_edges),
    .pass     (alive_pass)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    target_next = target_reg;
    sel_next    = sel_reg;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          target_next = req_sel;
          cnt_next    = '0;
          if (req_sel == cur_sel_reg) begin
            state_next = DONE;
          end else if (req_sel == SEL_CLK1) begin
            // clk1 is running by definition; no check needed
            state_next = SWITCH;
            sel_next   = SEL_CLK1;
          end else begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        // A pass seen in the last window cycle still wins over the timeout.
        if (alive_pass) begin
          state_next = SWITCH;
          sel_next   = target_reg;
          cnt_next   = '0;
        end else if (cnt_reg == WIN_LAST) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SWITCH: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      target_reg  <= SEL_CLK1;
      sel_reg     <= SEL_CLK1;
      cur_sel_reg <= SEL_CLK1;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      target_reg <= target_next;
      sel_reg    <= sel_next;
      ack_reg    <= (state_next == DONE);
      err_reg    <= err_next;
      busy_reg   <= (state_next != IDLE);
      if (state_next == DONE) begin
        cur_sel_reg <= sel_reg;
      end
    end
  end

  assign busy     = busy_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign sel_clk1 = sel_reg;
  assign cur_sel  = cur_sel_reg;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl. clk2 is a free-running clock of
// selectable period (or stopped); the reference model derives the expected
// ack time, error flag and select behaviour from the recorded clk2 samples.
module tb_clk_switch_ctrl;

  localparam int SETTLE = 32;
  localparam int WIN    = 64;
  localparam int MIN_E  = 4;
  localparam int HIST   = 20000;

  logic clk1;
  logic rstn;
  logic clk2_mon;
  logic req;
  logic req_sel;
  logic busy;
  logic ack;
  logic err;
  logic sel_clk1;
  logic cur_sel;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   samp[HIST];
  int   clk2_half = 35;
  bit   clk2_run  = 1'b1;
  logic m_sel;
  int   halves[7] = '{15, 25, 35, 45, 55, 125, 205};

  clk_switch_ctrl dut (
    .clk1     (clk1),
    .rstn     (rstn),
    .clk2_mon (clk2_mon),
    .req      (req),
    .req_sel  (req_sel),
    .busy     (busy),
    .ack      (ack),
    .err      (err),
    .sel_clk1 (sel_clk1),
    .cur_sel  (cur_sel)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // clk2 toggles at times offset 3 from multiples of 5, never on a clk1 edge.
  initial begin
    clk2_mon = 1'b0;
    #3;
    forever begin
      #(clk2_half);
      if (clk2_run) clk2_mon = ~clk2_mon;
    end
  end

  // Cycle index and the clk2 value captured at each clk1 rising edge.
  always @(posedge clk1) begin
    cyc = cyc + 1;
    if (cyc < HIST) samp[cyc] = clk2_mon;
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  // A clk2 level change captured at edge i is seen by the sequencer two
  // cycles later; only detections made while checking (cycles n+1 onward)
  // count. Returns k, the CHECK cycle index at which the count first reaches
  // MIN_E, or 0 if the window expires first.
  function automatic int first_pass(input int n);
    for (int t = n + 1; t <= n + WIN; t++) begin
      int edges = 0;
      for (int i = n + 1; i <= t - 1; i++) begin
        if (samp[i-1] != samp[i-2]) edges++;
      end
      if (edges >= MIN_E) return t - n;
    end
    return 0;
  endfunction

  task automatic run_txn(input logic tsel, input bit mid_req);
    int   n;
    int   ack_cnt;
    int   ack_at;
    logic err_at;
    logic cur_at;
    int   chg_cnt;
    int   chg_at;
    logic prev_sel;
    logic busy_first;
    logic busy_after;
    int   exp_ack;
    logic exp_err;
    int   exp_chg;
    int   exp_chg_at;
    logic new_sel;
    int   k;

    ack_cnt = 0; ack_at = 0; err_at = 1'b0; cur_at = 1'b0;
    chg_cnt = 0; chg_at = 0; busy_first = 1'b0; busy_after = 1'b1;
    req      = 1'b1;
    req_sel  = tsel;
    n        = cyc;
    prev_sel = sel_clk1;
    for (int c = 0; c < 150; c++) begin
      step();
      req = 1'b0;
      if (mid_req && cyc == n + 4) begin
        req     = 1'b1;
        req_sel = 1'($urandom_range(0, 1));
      end
      if (cyc == n + 1) busy_first = busy;
      if (sel_clk1 !== prev_sel) begin
        chg_cnt++;
        chg_at = cyc;
      end
      prev_sel = sel_clk1;
      if (ack === 1'b1) begin
        ack_cnt++;
        ack_at = cyc;
        err_at = err;
        cur_at = cur_sel;
      end
      if (ack_cnt > 0 && cyc == ack_at + 1) busy_after = busy;
      if (ack_cnt > 0 && cyc == ack_at + 2) break;
    end

    // Reference model
    exp_chg_at = 0;
    if (tsel == m_sel) begin
      exp_ack = n + 1; exp_err = 1'b0; exp_chg = 0; new_sel = m_sel;
    end else if (tsel == 1'b1) begin
      exp_ack = n + 2 + SETTLE; exp_err = 1'b0; exp_chg = 1;
      exp_chg_at = n + 1; new_sel = 1'b1;
    end else begin
      k = first_pass(n);
      if (k > 0) begin
        exp_ack = n + k + 2 + SETTLE; exp_err = 1'b0; exp_chg = 1;
        exp_chg_at = n + k + 1; new_sel = 1'b0;
      end else begin
        exp_ack = n + WIN + 1; exp_err = 1'b1; exp_chg = 0; new_sel = m_sel;
      end
    end

    $display("txn n=%0d sel %0d->%0d mid=%0d: ack@%0d (exp %0d) err=%0d (exp %0d) sel_chg@%0d",
             n, m_sel, tsel, mid_req, ack_at, exp_ack, err_at, exp_err, chg_at);
    chk("ack_count", ack_cnt, 1);
    chk("ack_cycle", ack_at, exp_ack);
    chk("err", err_at, exp_err);
    chk("busy_after_req", busy_first, 1);
    chk("busy_after_ack", busy_after, 0);
    chk("sel_changes", chg_cnt, exp_chg);
    if (exp_chg == 1) chk("sel_change_cycle", chg_at, exp_chg_at);
    chk("cur_sel_at_ack", cur_at, new_sel);
    chk("sel_clk1_final", sel_clk1, new_sel);
    m_sel = new_sel;
  endtask

  initial begin
    logic seen;
    rstn    = 1'b0;
    req     = 1'b0;
    req_sel = 1'b1;
    m_sel   = 1'b1;
    repeat (3) step();
    #2 rstn = 1'b1;

    // Idle after reset: defaults held
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_sel_clk1", sel_clk1, 1);
      chk("idle_cur_sel", cur_sel, 1);
      chk("idle_busy", busy, 0);
      chk("idle_ack", ack, 0);
      chk("idle_err", err, 0);
    end

    // clk2 period of 7 clk1 cycles: switch to clk2
    clk2_half = 35; clk2_run = 1'b1;
    repeat (3) step();
    run_txn(1'b0, 1'b0);
    // same-select request
    step();
    run_txn(1'b0, 1'b0);
    // back to clk1 with a dropped request during SETTLE
    step();
    run_txn(1'b1, 1'b1);
    // clk2 stuck: check fails, select unchanged
    clk2_run = 1'b0;
    repeat (5) step();
    run_txn(1'b0, 1'b1);

    // Reset during SETTLE toward clk2
    clk2_run = 1'b1; clk2_half = 35;
    repeat (3) step();
    if (m_sel !== 1'b1) run_txn(1'b1, 1'b0);
    req = 1'b1; req_sel = 1'b0;
    step();
    req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (sel_clk1 === 1'b0) seen = 1'b1;
      else step();
    end
    chk("rst_reach_switch", seen, 1);
    repeat (5) step();
    #3 rstn = 1'b0;
    #1;
    $display("reset asserted mid-SETTLE: sel_clk1=%0d busy=%0d ack=%0d cur_sel=%0d",
             sel_clk1, busy, ack, cur_sel);
    chk("rst_sel_clk1", sel_clk1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_cur_sel", cur_sel, 1);
    chk("rst_err", err, 0);
    repeat (3) begin
      step();
      chk("rst_hold_ack", ack, 0);
    end
    #2 rstn = 1'b1;
    m_sel = 1'b1;
    repeat (2) step();
    run_txn(1'b0, 1'b0);

    // Randomized transactions over clk2 periods, stopped clk2 and targets
    for (int t = 0; t < 25; t++) begin
      int  mode;
      logic tsel;
      bit  mid;
      mode = $urandom_range(0, 7);
      if (mode == 7) begin
        clk2_run = 1'b0;
      end else begin
        clk2_run  = 1'b1;
        clk2_half = halves[mode];
      end
      repeat ($urandom_range(1, 6)) step();
      tsel = 1'($urandom_range(0, 1));
      mid  = (tsel != m_sel) && ($urandom_range(0, 1) == 1);
      run_txn(tsel, mid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
